// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - Moore control FSM for the shared multicycle MIPS datapath
//
// Sequences one memory, one ALU, IR, PC and register file through
// fetch/decode/execute/writeback for R-type, lw, sw and beq.
// Optional: define MULTICYCLE_JUMP_EN to add the JUMP state for opcode 000010.
//
// Ports:
//   clk, rstN       rising-edge clock, asynchronous active-low reset
//   opcode          IR[31:26], valid from DECODE onward
//   memReady        memory completes the current access this cycle
//   pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite,
//   memToReg, regDst, regWrite, ALUSrcA, ALUSrcB, ALUOp, pcSource
//                   datapath controls
//   illegalOp       one-cycle pulse in DECODE on an unsupported opcode
//   stateOut        current state encoding (debug)
//   instrCount      retired-instruction counter, wraps

module multicycle_control #(
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rstN,
  input  logic [5:0]             opcode,
  input  logic                   memReady,
  output logic                   pcWrite,
  output logic                   pcWriteCond,
  output logic                   iorD,
  output logic                   memRead,
  output logic                   memWrite,
  output logic                   irWrite,
  output logic                   memToReg,
  output logic                   regDst,
  output logic                   regWrite,
  output logic                   ALUSrcA,
  output logic [1:0]             ALUSrcB,
  output logic [1:0]             ALUOp,
  output logic [1:0]             pcSource,
  output logic                   illegalOp,
  output logic [3:0]             stateOut,
  output logic [COUNT_WIDTH-1:0] instrCount
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
`ifdef MULTICYCLE_JUMP_EN
  localparam logic [5:0] OP_J     = 6'b000010;
`endif

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
`ifdef MULTICYCLE_JUMP_EN
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9
`else
    S_BRANCH  = 4'd8
`endif
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;

  logic       retire;
  logic       pc_write, pc_write_cond, ior_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_source;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= S_FETCH;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d       = S_FETCH;
    retire        = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ior_d         = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    illegal_op    = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        // IR and PC+4 commit only on the cycle the read actually completes
        ir_write  = memReady;
        pc_write  = memReady;
        state_d   = memReady ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_RTYPE:      state_d = S_EXECUTE;
          OP_LW, OP_SW:  state_d = S_MEMADR;
          OP_BEQ:        state_d = S_BRANCH;
`ifdef MULTICYCLE_JUMP_EN
          OP_J:          state_d = S_JUMP;
`endif
          default: begin
            illegal_op = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        if (opcode == OP_LW)      state_d = S_MEMRD;
        else if (opcode == OP_SW) state_d = S_MEMWR;
        else                      state_d = S_FETCH;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        ior_d    = 1'b1;
        state_d  = memReady ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        ior_d     = 1'b1;
        retire    = memReady;
        state_d   = memReady ? S_FETCH : S_MEMWR;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retire    = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        retire        = 1'b1;
      end
`ifdef MULTICYCLE_JUMP_EN
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        retire    = 1'b1;
      end
`endif
      default: state_d = S_FETCH;
    endcase

    count_d = retire ? count_q + COUNT_ONE : count_q;
  end

  // Reset must silence every strobe at once, not at the next edge
  assign pcWrite     = rstN & pc_write;
  assign pcWriteCond = rstN & pc_write_cond;
  assign iorD        = rstN & ior_d;
  assign memRead     = rstN & mem_read;
  assign memWrite    = rstN & mem_write;
  assign irWrite     = rstN & ir_write;
  assign memToReg    = rstN & mem_to_reg;
  assign regDst      = rstN & reg_dst;
  assign regWrite    = rstN & reg_write;
  assign ALUSrcA     = rstN & alu_src_a;
  assign ALUSrcB     = rstN ? alu_src_b : 2'b00;
  assign ALUOp       = rstN ? alu_op    : 2'b00;
  assign pcSource    = rstN ? pc_source : 2'b00;
  assign illegalOp   = rstN & illegal_op;
  assign stateOut    = rstN ? state_q   : 4'd0;
  assign instrCount  = rstN ? count_q   : '0;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - table-driven bench for multicycle_control

module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic [5:0]  opcode = 6'd0;
  logic        memReady = 1'b1;

  logic        pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite;
  logic        memToReg, regDst, regWrite, ALUSrcA, illegalOp;
  logic [1:0]  ALUSrcB, ALUOp, pcSource;
  logic [3:0]  stateOut;
  logic [31:0] instrCount;

  logic        w2_pcWrite, w2_pcWriteCond, w2_iorD, w2_memRead, w2_memWrite, w2_irWrite;
  logic        w2_memToReg, w2_regDst, w2_regWrite, w2_ALUSrcA, w2_illegalOp;
  logic [1:0]  w2_ALUSrcB, w2_ALUOp, w2_pcSource;
  logic [3:0]  w2_stateOut;
  logic [1:0]  w2_instrCount;

  always #5 clk = ~clk;

  multicycle_control #(.COUNT_WIDTH(32)) dut (
    .clk(clk), .rstN(rstN), .opcode(opcode), .memReady(memReady),
    .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .iorD(iorD),
    .memRead(memRead), .memWrite(memWrite), .irWrite(irWrite),
    .memToReg(memToReg), .regDst(regDst), .regWrite(regWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .pcSource(pcSource), .illegalOp(illegalOp), .stateOut(stateOut),
    .instrCount(instrCount)
  );

  // Narrow counter copy exposes modulo wrap within a short run
  multicycle_control #(.COUNT_WIDTH(2)) dut_w2 (
    .clk(clk), .rstN(rstN), .opcode(opcode), .memReady(memReady),
    .pcWrite(w2_pcWrite), .pcWriteCond(w2_pcWriteCond), .iorD(w2_iorD),
    .memRead(w2_memRead), .memWrite(w2_memWrite), .irWrite(w2_irWrite),
    .memToReg(w2_memToReg), .regDst(w2_regDst), .regWrite(w2_regWrite),
    .ALUSrcA(w2_ALUSrcA), .ALUSrcB(w2_ALUSrcB), .ALUOp(w2_ALUOp),
    .pcSource(w2_pcSource), .illegalOp(w2_illegalOp), .stateOut(w2_stateOut),
    .instrCount(w2_instrCount)
  );

  // {pcWrite,pcWriteCond,iorD,memRead,memWrite,irWrite,memToReg,regDst,
  //  regWrite,ALUSrcA,ALUSrcB,ALUOp,pcSource,illegalOp}
  logic [16:0] act_out;
  assign act_out = {pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite,
                    memToReg, regDst, regWrite, ALUSrcA, ALUSrcB, ALUOp,
                    pcSource, illegalOp};

  localparam logic [16:0] O_ZERO       = 17'd0;
  localparam logic [16:0] O_FETCH_RDY  = {1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0};
  localparam logic [16:0] O_FETCH_WAIT = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0};
  localparam logic [16:0] O_DECODE     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b0};
  localparam logic [16:0] O_DECODE_ILL = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b1};
  localparam logic [16:0] O_MEMADR     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0};
  localparam logic [16:0] O_MEMRD      = {1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0};
  localparam logic [16:0] O_MEMWB      = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0};
  localparam logic [16:0] O_MEMWR      = {1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0};
  localparam logic [16:0] O_EXEC       = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b10,2'b00,1'b0};
  localparam logic [16:0] O_ALUWB      = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0};
  localparam logic [16:0] O_BRANCH     = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,2'b01,1'b0};
  localparam logic [16:0] O_JUMP       = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b10,1'b0};

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_ILL = 6'b001000;
  localparam logic [5:0] OP_J   = 6'b000010;

  typedef struct {
    logic        rstn;
    logic [5:0]  op;
    logic        rdy;
    logic [3:0]  st;
    logic [16:0] out;
    int unsigned cnt;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic vec_t mk(logic rstn, logic [5:0] op, logic rdy,
                              logic [3:0] st, logic [16:0] out, int unsigned cnt);
    vec_t v;
    v.rstn = rstn; v.op = op; v.rdy = rdy; v.st = st; v.out = out; v.cnt = cnt;
    return v;
  endfunction

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s step %0d: got 0x%0h, expected 0x%0h", name, idx, act, exp);
  endtask

  task automatic check_cycle(input int idx, input logic [3:0] st,
                             input logic [16:0] out, input int unsigned cnt);
    check("stateOut", idx, {28'd0, stateOut}, {28'd0, st});
    check("outputs", idx, {15'd0, act_out}, {15'd0, out});
    check("instrCount", idx, instrCount, cnt);
    check("instrCount_w2", idx, {30'd0, w2_instrCount}, cnt % 4);
  endtask

  initial begin
    // reset held
    vecs.push_back(mk(0, OP_R,   1, 0, O_ZERO,       0));
    // R-type; memReady low in non-memory states must not stall
    vecs.push_back(mk(1, OP_R,   1, 0, O_FETCH_RDY,  0));
    vecs.push_back(mk(1, OP_R,   0, 1, O_DECODE,     0));
    vecs.push_back(mk(1, OP_R,   0, 6, O_EXEC,       0));
    vecs.push_back(mk(1, OP_R,   1, 7, O_ALUWB,      0));
    // lw with two MEMRD wait cycles
    vecs.push_back(mk(1, OP_LW,  1, 0, O_FETCH_RDY,  1));
    vecs.push_back(mk(1, OP_LW,  1, 1, O_DECODE,     1));
    vecs.push_back(mk(1, OP_LW,  1, 2, O_MEMADR,     1));
    vecs.push_back(mk(1, OP_LW,  0, 3, O_MEMRD,      1));
    vecs.push_back(mk(1, OP_LW,  0, 3, O_MEMRD,      1));
    vecs.push_back(mk(1, OP_LW,  1, 3, O_MEMRD,      1));
    vecs.push_back(mk(1, OP_LW,  1, 4, O_MEMWB,      1));
    // sw with fetch wait and one MEMWR wait
    vecs.push_back(mk(1, OP_SW,  0, 0, O_FETCH_WAIT, 2));
    vecs.push_back(mk(1, OP_SW,  1, 0, O_FETCH_RDY,  2));
    vecs.push_back(mk(1, OP_SW,  1, 1, O_DECODE,     2));
    vecs.push_back(mk(1, OP_SW,  1, 2, O_MEMADR,     2));
    vecs.push_back(mk(1, OP_SW,  0, 5, O_MEMWR,      2));
    vecs.push_back(mk(1, OP_SW,  1, 5, O_MEMWR,      2));
    // beq
    vecs.push_back(mk(1, OP_BEQ, 1, 0, O_FETCH_RDY,  3));
    vecs.push_back(mk(1, OP_BEQ, 1, 1, O_DECODE,     3));
    vecs.push_back(mk(1, OP_BEQ, 0, 8, O_BRANCH,     3));
    // illegal opcode: no retire
    vecs.push_back(mk(1, OP_ILL, 1, 0, O_FETCH_RDY,  4));
    vecs.push_back(mk(1, OP_ILL, 1, 1, O_DECODE_ILL, 4));
    // jump
    vecs.push_back(mk(1, OP_J,   1, 0, O_FETCH_RDY,  4));
`ifdef MULTICYCLE_JUMP_EN
    vecs.push_back(mk(1, OP_J,   1, 1, O_DECODE,     4));
    vecs.push_back(mk(1, OP_J,   1, 9, O_JUMP,       4));
    vecs.push_back(mk(1, OP_R,   1, 0, O_FETCH_RDY,  5));
`else
    vecs.push_back(mk(1, OP_J,   1, 1, O_DECODE_ILL, 4));
    vecs.push_back(mk(1, OP_R,   1, 0, O_FETCH_RDY,  4));
`endif

    foreach (vecs[i]) begin
      @(negedge clk);
      rstN     = vecs[i].rstn;
      opcode   = vecs[i].op;
      memReady = vecs[i].rdy;
      #1;
      check_cycle(i, vecs[i].st, vecs[i].out, vecs[i].cnt);
    end

    // Finish the R-type fetched by the last row so the count is known
    @(negedge clk); opcode = OP_R; memReady = 1'b1;   // DECODE
    @(negedge clk);                                    // EXECUTE
    @(negedge clk);                                    // ALUWB
    @(negedge clk);                                    // FETCH
    #1;
`ifdef MULTICYCLE_JUMP_EN
    check_cycle(100, 4'd0, O_FETCH_RDY, 6);
`else
    check_cycle(100, 4'd0, O_FETCH_RDY, 5);
`endif

    // Reset mid-MEMWR: strobe must drop without waiting for a clock edge
    opcode = OP_SW;
    @(negedge clk);                                    // DECODE
    @(negedge clk);                                    // MEMADR
    @(negedge clk); memReady = 1'b0;                   // MEMWR, stalled
    #1;
    check("memwr_before_rst", 101, {28'd0, stateOut}, 32'd5);
    check("memWrite_before_rst", 101, {31'd0, memWrite}, 32'd1);
    #2;
    rstN = 1'b0;
    #1;
    check("memWrite_in_rst", 102, {31'd0, memWrite}, 32'd0);
    check_cycle(102, 4'd0, O_ZERO, 0);
    @(negedge clk);
    rstN = 1'b1; memReady = 1'b1; opcode = OP_R;
    #1;
    check_cycle(103, 4'd0, O_FETCH_RDY, 0);
    @(negedge clk);
    #1;
    check_cycle(104, 4'd1, O_DECODE, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Moore FSM that sequences the shared multicycle MIPS datapath: single memory, single ALU, IR, PC, register file. Replaces the single-cycle opcode decoder in the multicycle core variant. Supports R-type, lw, sw and beq. Stalls on a memory ready handshake, flags illegal opcodes, and counts retired instructions.

Parameters:
COUNT_WIDTH, 32, width of retired-instruction counter instrCount

Ports:
clk  input  1  rising-edge clock
rstN  input  1  asynchronous active-low reset
opcode  input  6  IR[31:26], valid from DECODE onward
memReady  input  1  memory completes the current access this cycle
pcWrite  output  1  unconditional PC load
pcWriteCond  output  1  PC load if ALU zero
iorD  output  1  memory address select: 0=PC, 1=ALUOut
memRead  output  1  memory read strobe
memWrite  output  1  memory write strobe
irWrite  output  1  IR load
memToReg  output  1  writeback select: 1=MDR, 0=ALUOut
regDst  output  1  1=rd, 0=rt
regWrite  output  1  register file write
ALUSrcA  output  1  0=PC, 1=A
ALUSrcB  output  2  00=B, 01=4, 10=signext imm, 11=signext imm<<2
ALUOp  output  2  00=add, 01=sub, 10=funct decode
pcSource  output  2  00=ALU result, 01=ALUOut, 10=jump target
illegalOp  output  1  one-cycle pulse, unsupported opcode
stateOut  output  4  current state encoding, debug
instrCount  output  COUNT_WIDTH  retired instructions

Behaviour:
- Asynchronous active-low reset: state=FETCH, instrCount=0. While rstN=0, every output is forced to 0 combinationally, including strobes, selects, illegalOp and stateOut.
- Outputs are a combinational function of state, plus memReady qualification. Outputs not listed for a state are driven to 0. No X is ever driven.
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, JUMP=9. Encodings 10-15 go to FETCH on the next edge with all outputs 0.
- FETCH:
  - Outputs: memRead=1, iorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, pcSource=00, irWrite=memReady, pcWrite=memReady.
  - Holds until memReady=1, then goes to DECODE.
- DECODE:
  - Outputs: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target precompute).
  - Next state by opcode: 000000 to EXECUTE; 100011/101011 to MEMADR; 000100 to BRANCH.
  - Any other opcode: illegalOp=1 this cycle, go to FETCH, instruction not counted.
- MEMADR:
  - Outputs: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - lw goes to MEMRD, sw goes to MEMWR. Opcode is held stable by IR.
- MEMRD:
  - Outputs: memRead=1, iorD=1.
  - Holds until memReady, then goes to MEMWB.
- MEMWB:
  - Outputs: regWrite=1, memToReg=1, regDst=0.
  - Goes to FETCH.
- MEMWR:
  - Outputs: memWrite=1, iorD=1.
  - Holds until memReady, then goes to FETCH.
- EXECUTE:
  - Outputs: ALUSrcA=1, ALUSrcB=00, ALUOp=10.
  - Goes to ALUWB.
- ALUWB:
  - Outputs: regWrite=1, regDst=1, memToReg=0.
  - Goes to FETCH.
- BRANCH:
  - Outputs: ALUSrcA=1, ALUSrcB=00, ALUOp=01, pcWriteCond=1, pcSource=01.
  - Goes to FETCH.
- Retire: instrCount increments by 1 on the edge leaving MEMWB, ALUWB, BRANCH or JUMP, and on the edge leaving MEMWR with memReady=1. It wraps modulo 2^COUNT_WIDTH; no saturation.
- Latency with memReady tied 1: R-type 4 cycles, lw 5, sw 4, beq 3, jump 3. Each memory wait cycle adds 1.
- memReady is ignored in states without a memory access.
- Reset mid-access: strobes drop immediately (asynchronous), FETCH is entered, and an in-flight instruction is not counted.

Optional Feature:
MULTICYCLE_JUMP_EN
- Defined: opcode 000010 in DECODE goes to JUMP. JUMP outputs pcWrite=1 and pcSource=10, goes to FETCH, and counts as retired.
- Undefined: JUMP state absent; 000010 is treated as illegal (illegalOp pulse, no retire). Encoding 9 goes to FETCH like other unused encodings.

Test Plan:
- Reset released, memReady=1, opcode=000000: stateOut sequence 0,1,6,7,0. regWrite=1 and regDst=1 only in state 7. instrCount=1.
- lw (100011), memReady held 0 for 2 cycles in MEMRD: sequence 0,1,2,3,3,3,4,0. memRead=1, iorD=1 for all three MEMRD cycles. instrCount=1.
- sw (101011), memReady=0 in first FETCH cycle: irWrite=0 and pcWrite=0 that cycle, both 1 the next. memWrite=1 exactly one cycle.
- beq (000100): sequence 0,1,8,0. pcWriteCond=1, pcSource=01, ALUOp=01 in state 8. Count increments.
- opcode=001000: illegalOp=1 for one cycle in DECODE, then FETCH. instrCount unchanged.
- rstN pulled low mid-MEMWR: memWrite=0 immediately, stateOut=0, instrCount=0. After release, fetch resumes. With MULTICYCLE_JUMP_EN, 000010 gives sequence 0,1,9,0 with pcSource=10.
